// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register with write-back data select, forwarding bus and retire counter
module wb_stage #(
  parameter int WORD_SIZE = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic                 mem_reg_write,
  input  logic [1:0]           mem_to_reg,
  input  logic [2:0]           mem_load_type,
  input  logic [4:0]           mem_write_reg,
  input  logic [WORD_SIZE-1:0] mem_alu_result,
  input  logic [WORD_SIZE-1:0] mem_read_data,
  input  logic [WORD_SIZE-1:0] mem_link_addr,
  output logic                 regfile_write_en,
  output logic [4:0]           regfile_write_addr,
  output logic [WORD_SIZE-1:0] regfile_write_data,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_reg,
  output logic [WORD_SIZE-1:0] fwd_data,
  output logic                 addr_error,
  output logic [CNT_WIDTH-1:0] retire_count
);
  logic                 valid_q, valid_d, rw_q, rw_d;
  logic [1:0]           to_reg_q, to_reg_d;
  logic [2:0]           lt_q, lt_d;
  logic [4:0]           wr_q, wr_d;
  logic [WORD_SIZE-1:0] alu_q, alu_d, rd_q, rd_d, link_q, link_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 hold, mis, is_half, is_word;
  logic [1:0]           off;
  logic [15:0]          half;
  logic [7:0]           byte_v;
  logic [WORD_SIZE-1:0] shifted, load_v, data_v;
  always_comb begin
    hold     = stall & ~flush;
    valid_d  = flush ? 1'b0 : hold ? valid_q : mem_valid;
    rw_d     = flush ? 1'b0 : hold ? rw_q : mem_reg_write;
    to_reg_d = hold ? to_reg_q : mem_to_reg;
    lt_d     = hold ? lt_q : mem_load_type;
    wr_d     = hold ? wr_q : mem_write_reg;
    alu_d    = hold ? alu_q : mem_alu_result;
    rd_d     = hold ? rd_q : mem_read_data;
    link_d   = hold ? link_q : mem_link_addr;
    // the held entry is counted on the edge it leaves, so stalls count once
    cnt_d    = cnt_q + CNT_WIDTH'(valid_q & ~hold);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      rw_q     <= 1'b0;
      to_reg_q <= '0;
      lt_q     <= '0;
      wr_q     <= '0;
      alu_q    <= '0;
      rd_q     <= '0;
      link_q   <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      rw_q     <= rw_d;
      to_reg_q <= to_reg_d;
      lt_q     <= lt_d;
      wr_q     <= wr_d;
      alu_q    <= alu_d;
      rd_q     <= rd_d;
      link_q   <= link_d;
      cnt_q    <= cnt_d;
    end
  end
  always_comb begin
    off     = alu_q[1:0];
    half    = off[1] ? rd_q[31:16] : rd_q[15:0];
    shifted = rd_q >> {off, 3'b000};
    byte_v  = shifted[7:0];
    is_half = (lt_q == 3'd1) | (lt_q == 3'd2);
    is_word = ~is_half & (lt_q != 3'd3) & (lt_q != 3'd4);
    load_v  = (lt_q == 3'd1) ? {{(WORD_SIZE-16){half[15]}}, half} :
              (lt_q == 3'd2) ? {{(WORD_SIZE-16){1'b0}}, half} :
              (lt_q == 3'd3) ? {{(WORD_SIZE-8){byte_v[7]}}, byte_v} :
              (lt_q == 3'd4) ? {{(WORD_SIZE-8){1'b0}}, byte_v} : rd_q;
    mis     = (to_reg_q == 2'b01) & ((is_word & (off != 2'b00)) | (is_half & off[0]));
    data_v  = (to_reg_q == 2'b00) ? alu_q :
              (to_reg_q == 2'b01) ? load_v :
              (to_reg_q == 2'b10) ? link_q : '0;
    addr_error         = valid_q & mis;
    regfile_write_en   = valid_q & rw_q & (wr_q != 5'd0) & ~mis & (to_reg_q != 2'b11);
    regfile_write_addr = wr_q;
    regfile_write_data = data_v;
    fwd_valid          = regfile_write_en;
    fwd_reg            = wr_q;
    fwd_data           = data_v;
    retire_count       = cnt_q;
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors into wb_stage, expectations queued and checked by a separate monitor
module tb_wb_stage;
  logic        clk = 0, rst = 1, stall = 0, flush = 0, mem_valid = 0, mem_reg_write = 0;
  logic [1:0]  mem_to_reg = 0;
  logic [2:0]  mem_load_type = 0;
  logic [4:0]  mem_write_reg = 0;
  logic [31:0] mem_alu_result = 0, mem_read_data = 0, mem_link_addr = 0;
  logic        regfile_write_en, fwd_valid, addr_error;
  logic [4:0]  regfile_write_addr, fwd_reg;
  logic [31:0] regfile_write_data, fwd_data, retire_count;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write), .mem_to_reg(mem_to_reg), .mem_load_type(mem_load_type),
    .mem_write_reg(mem_write_reg), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data), .mem_link_addr(mem_link_addr),
    .regfile_write_en(regfile_write_en), .regfile_write_addr(regfile_write_addr),
    .regfile_write_data(regfile_write_data), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
    .fwd_data(fwd_data), .addr_error(addr_error), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        aerr;
    logic [31:0] cnt;
    logic        ad_dc;
  } exp_t;

  exp_t q[$];
  int compared = 0, mismatched = 0;
  logic        m_valid = 0;
  logic [31:0] m_cnt = 0;

  // retire-count model: counted on the edge a valid entry leaves the register
  task automatic issue(input string name, input logic r, input logic s, input logic f,
                       input logic v, input logic rw, input logic [1:0] tr, input logic [2:0] lt,
                       input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] lk, input logic e_en, input logic [4:0] e_addr,
                       input logic [31:0] e_data, input logic e_aerr, input logic dc);
    exp_t e;
    rst = r; stall = s; flush = f; mem_valid = v; mem_reg_write = rw; mem_to_reg = tr;
    mem_load_type = lt; mem_write_reg = wr; mem_alu_result = alu; mem_read_data = rd;
    mem_link_addr = lk;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_valid = 0;
    end else begin
      if (m_valid && (f || !s)) m_cnt = m_cnt + 1;
      m_valid = f ? 1'b0 : s ? m_valid : v;
    end
    e.name = name; e.en = e_en; e.addr = e_addr; e.data = e_data; e.aerr = e_aerr;
    e.cnt = m_cnt; e.ad_dc = dc;
    q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic ok;
      e = q.pop_front();
      ok = regfile_write_en == e.en && fwd_valid == e.en && addr_error == e.aerr &&
           retire_count == e.cnt &&
           (e.ad_dc || (regfile_write_addr == e.addr && fwd_reg == e.addr &&
                        regfile_write_data == e.data && fwd_data == e.data));
      compared++;
      if (!ok) begin
        mismatched++;
        $display("FAIL %s: got en=%0b/%0b addr=%0d/%0d data=%h/%h aerr=%0b cnt=%0d, want en=%0b addr=%0d data=%h aerr=%0b cnt=%0d",
                 e.name, regfile_write_en, fwd_valid, regfile_write_addr, fwd_reg,
                 regfile_write_data, fwd_data, addr_error, retire_count,
                 e.en, e.addr, e.data, e.aerr, e.cnt);
      end
    end
  end

  initial begin
    //     name        rst s f v rw tr     lt    wr  alu           rd            link          en addr data          aerr dc
    issue("reset0",    1, 0,0,1,1, 2'b00, 3'd0, 8, 32'h1234,     32'h0,        32'h0,        0, 0,  32'h0,        0, 0);
    issue("reset1",    1, 0,0,1,1, 2'b00, 3'd0, 8, 32'h1234,     32'h0,        32'h0,        0, 0,  32'h0,        0, 0);
    issue("alu",       0, 0,0,1,1, 2'b00, 3'd0, 8, 32'h1234,     32'h0,        32'h0,        1, 8,  32'h1234,     0, 0);
    issue("lb_off2",   0, 0,0,1,1, 2'b01, 3'd3, 9, 32'h102,      32'h80FF7F01, 32'h0,        1, 9,  32'hFFFFFFFF, 0, 0);
    issue("lbu_off2",  0, 0,0,1,1, 2'b01, 3'd4, 9, 32'h102,      32'h80FF7F01, 32'h0,        1, 9,  32'h000000FF, 0, 0);
    issue("lb_off3",   0, 0,0,1,1, 2'b01, 3'd3, 9, 32'h103,      32'h80FF7F01, 32'h0,        1, 9,  32'hFFFFFF80, 0, 0);
    issue("lh_off2",   0, 0,0,1,1, 2'b01, 3'd1, 9, 32'h102,      32'h80FF7F01, 32'h0,        1, 9,  32'hFFFF80FF, 0, 0);
    issue("lhu_off2",  0, 0,0,1,1, 2'b01, 3'd2, 9, 32'h102,      32'h80FF7F01, 32'h0,        1, 9,  32'h000080FF, 0, 0);
    issue("lb_off0",   0, 0,0,1,1, 2'b01, 3'd3, 9, 32'h100,      32'h80FF7F01, 32'h0,        1, 9,  32'h00000001, 0, 0);
    issue("lw_mis",    0, 0,0,1,1, 2'b01, 3'd0,10, 32'h1001,     32'hDEADBEEF, 32'h0,        0,10,  32'hDEADBEEF, 1, 0);
    issue("lh_mis",    0, 0,0,1,1, 2'b01, 3'd1,10, 32'h1003,     32'hDEADBEEF, 32'h0,        0,10,  32'hFFFFDEAD, 1, 0);
    issue("alu_r0",    0, 0,0,1,1, 2'b00, 3'd0, 0, 32'h55,       32'h0,        32'h0,        0, 0,  32'h55,       0, 0);
    issue("link",      0, 0,0,1,1, 2'b10, 3'd0,31, 32'h9,        32'h0,        32'h00400010, 1,31,  32'h00400010, 0, 0);
    issue("stall1",    0, 1,0,1,1, 2'b00, 3'd0, 3, 32'hAAAA,     32'h0,        32'h0,        1,31,  32'h00400010, 0, 0);
    issue("stall2",    0, 1,0,1,1, 2'b00, 3'd0, 3, 32'hAAAA,     32'h0,        32'h0,        1,31,  32'h00400010, 0, 0);
    issue("stall3",    0, 1,0,1,1, 2'b00, 3'd0, 3, 32'hAAAA,     32'h0,        32'h0,        1,31,  32'h00400010, 0, 0);
    issue("release",   0, 0,0,1,1, 2'b00, 3'd0, 5, 32'h77,       32'h0,        32'h0,        1, 5,  32'h77,       0, 0);
    issue("stl_flush", 0, 1,1,1,1, 2'b00, 3'd0, 6, 32'h88,       32'h0,        32'h0,        0, 0,  32'h0,        0, 1);
    issue("rsv_toreg", 0, 0,0,1,1, 2'b11, 3'd0, 6, 32'h99,       32'h0,        32'h0,        0, 6,  32'h0,        0, 0);
    issue("sw_nowr",   0, 0,0,1,0, 2'b00, 3'd0, 4, 32'h44,       32'h0,        32'h0,        0, 4,  32'h44,       0, 0);
    issue("lw_ok",     0, 0,0,1,1, 2'b01, 3'd0, 7, 32'h2000,     32'h12345678, 32'h0,        1, 7,  32'h12345678, 0, 0);
    issue("bubble",    0, 0,0,0,1, 2'b00, 3'd0, 2, 32'h22,       32'h0,        32'h0,        0, 2,  32'h22,       0, 0);
    issue("bubble2",   0, 0,0,0,0, 2'b00, 3'd0, 0, 32'h0,        32'h0,        32'h0,        0, 0,  32'h0,        0, 0);
    issue("pre_rst",   0, 0,0,1,1, 2'b00, 3'd0,12, 32'hC0DE,     32'h0,        32'h0,        1,12,  32'hC0DE,     0, 0);
    issue("stall_hd",  0, 1,0,1,1, 2'b00, 3'd0,13, 32'hBAD,      32'h0,        32'h0,        1,12,  32'hC0DE,     0, 0);
    issue("rst_stall", 1, 1,0,1,1, 2'b00, 3'd0,13, 32'hBAD,      32'h0,        32'h0,        0, 0,  32'h0,        0, 0);
    issue("post_rst",  0, 0,0,1,1, 2'b00, 3'd0,14, 32'h1,        32'h0,        32'h0,        1,14,  32'h1,        0, 0);
    issue("idle",      0, 0,0,0,0, 2'b00, 3'd0, 0, 32'h0,        32'h0,        32'h0,        0, 0,  32'h0,        0, 0);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus write-back result path of the MIPS pipeline.
- Captures each instruction's ALU result, load data and control bits at the end of MEM, then drives the register-file write port one cycle later.
- Selects the write data: ALU result, sign/zero-extended load, or link address.
- Drives the write-back forwarding bus for the EX operand muxes.
- Keeps a retired-instruction counter.

Parameters:
WORD_SIZE, 32, datapath width; set equal to the WORD_SIZE definition. The block supports 32 only.
CNT_WIDTH, 32, width of retire_count.

Ports:
clk  in  1  rising-edge clock; the only clock
rst  in  1  synchronous, active-high reset
stall  in  1  hold the MEM/WB register contents
flush  in  1  load a bubble into the MEM/WB register
mem_valid  in  1  MEM stage holds a real instruction
mem_reg_write  in  1  instruction writes the register file
mem_to_reg  in  2  write-data source: 00 ALU result, 01 load data, 10 link address, 11 reserved
mem_load_type  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; other codes reserved
mem_write_reg  in  5  destination register number
mem_alu_result  in  WORD_SIZE  ALU result; also the load address
mem_read_data  in  WORD_SIZE  word read from data memory, little-endian
mem_link_addr  in  WORD_SIZE  PC+8 for jal/jalr
regfile_write_en  out  1  register-file write enable
regfile_write_addr  out  5  register-file write address
regfile_write_data  out  WORD_SIZE  register-file write data
fwd_valid  out  1  forwarding bus valid; equal to regfile_write_en
fwd_reg  out  5  forwarding register number
fwd_data  out  WORD_SIZE  forwarding data
addr_error  out  1  misaligned load retiring this cycle
retire_count  out  CNT_WIDTH  number of valid instructions retired since reset

Behaviour:
- Clocking: single clock clk; synchronous active-high reset rst.
- MEM/WB register update, evaluated at each rising edge in priority order:
  - rst: clear every field; the valid bit resets to 0.
  - flush: load a bubble (valid=0, reg_write=0). Other fields are don't-care. Flush overrides stall.
  - stall: hold all fields.
  - otherwise: capture all mem_* inputs.
- Reset values of outputs: regfile_write_en=0, regfile_write_addr=0, regfile_write_data=0, fwd_valid=0, fwd_reg=0, fwd_data=0, addr_error=0, retire_count=0.
- Latency: mem_* inputs sampled at edge N appear on the write-back outputs after edge N. Outputs are combinational from the register contents only, with no path from any input.
- Byte offset: off = registered alu_result[1:0].
- Load extraction:
  - lw: the full word.
  - lh / lhu: half = off[1] ? data[31:16] : data[15:0], then sign-extended (lh) or zero-extended (lhu).
  - lb / lbu: byte = data[8*off+7 : 8*off], then sign-extended (lb) or zero-extended (lbu).
  - Reserved load codes behave as lw.
- Misaligned load:
  - Condition: to_reg=01 and either (lw with off!=0) or (lh/lhu with off[0]=1).
  - When the instruction is also valid: addr_error=1 and the register write is suppressed.
- Reserved mem_to_reg code 11: write data is 0 and the write is suppressed.
- Write enable: regfile_write_en = valid & reg_write & (write_reg!=0) & ~addr_error & (to_reg!=11).
  - Writes to $0 are never issued.
- regfile_write_addr and regfile_write_data always show the registered values, including when the enable is 0.
- Forwarding bus: fwd_* mirror regfile_write_* exactly.
- A held (stalled) instruction keeps driving its write every cycle it is held. Repeated writes are idempotent.
- Retire counter:
  - Increments by 1 on each edge where valid=1 and the register advances, i.e. at the edge the held instruction leaves.
  - Advancing means not stalled, or flushed while holding a valid entry.
  - A stalled instruction is counted once, not per cycle held.
  - Misaligned loads, $0 writes and non-writing instructions (sw, branches) are counted.
  - Bubbles are not counted.
  - Wraps modulo 2^CNT_WIDTH.
- Reset mid-stall: the register clears immediately and the held instruction is discarded and not counted.

Test Plan:
- Reset: rst=1 for 2 cycles with mem_valid=1 → all outputs 0 and retire_count=0; after release, the first instruction's outputs appear one edge later.
- ALU write: alu_result=0x0000_1234, write_reg=8, to_reg=00 → next cycle regfile_write_en=1, addr=8, data=0x1234, fwd_* identical.
- Byte/half loads:
  - read_data=0x80FF_7F01, alu_result=0x...2, lb → 0xFFFF_FFFF; lbu → 0x0000_00FF.
  - alu_result=0x...3, lb → 0xFFFF_FF80.
  - alu_result=0x...2, lh → 0xFFFF_80FF; lhu → 0x0000_80FF.
- Misaligned and $0:
  - lw with alu_result=0x1001 → addr_error=1, regfile_write_en=0.
  - ALU write to write_reg=0 → regfile_write_en=0.
  - retire_count increments by 1 for each of the two.
- Stall/flush:
  - Hold stall=1 for 3 cycles on a valid instruction → outputs stable and retire_count unchanged; on release, +1.
  - stall=1 with flush=1 → bubble, regfile_write_en=0.
- Link: to_reg=10, link_addr=0x0040_0010, write_reg=31 → data=0x0040_0010, addr=31, en=1.
